// File: rtl/genram.sv
// Byte-addressed RAM with a single-cycle multi-byte read port and a serial
// write port that stores one byte per cycle, both checked against shared bounds.
module genram #(
   parameter int    AW       = 5,
   parameter int    DW       = 8,
   parameter int    EXTRA    = 4,
   parameter string INITFILE = ""
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [AW:0]                 addr,
   input  logic [EXTRA-1:0]            extra,
   input  logic [AW:0]                 lower_bound,
   input  logic [AW:0]                 upper_bound,
   output logic [(2**EXTRA)*DW-1:0]    data,
   output logic                        error,
   input  logic                        wr_valid,
   output logic                        wr_ready,
   input  logic [AW:0]                 wr_addr,
   input  logic [EXTRA-1:0]            wr_extra,
   input  logic [(2**EXTRA)*DW-1:0]    wr_data,
   output logic                        wr_done,
   output logic                        wr_error
);

   localparam int DEPTH = 2**(AW+1);
   localparam int NB    = 2**EXTRA;
   localparam int BW    = NB*DW;

   typedef enum logic {IDLE, WRITE} state_t;

   logic [DW-1:0]    mem [DEPTH];
   state_t           state;
   state_t           state_next;
   logic [EXTRA-1:0] cnt;
   logic [AW:0]      w_addr;
   logic [EXTRA-1:0] w_extra;
   logic [BW-1:0]    w_data;
   logic [BW-1:0]    rd_next;
   logic             rd_ok;
   logic             wr_ok;

   // One extra bit keeps addr+extra from wrapping, so an access past the top of memory is flagged.
   function automatic logic in_bounds(input logic [AW:0] a, input logic [EXTRA-1:0] e,
                                      input logic [AW:0] lo, input logic [AW:0] hi);
      logic [AW+1:0] last;
      last = {1'b0, a} + (AW+2)'(e);
      return (a >= lo) && (last <= {1'b0, hi});
   endfunction

   assign rd_ok = in_bounds(addr, extra, lower_bound, upper_bound);
   assign wr_ok = in_bounds(wr_addr, wr_extra, lower_bound, upper_bound);

   always_comb begin
      rd_next = '0;
      for (int i = 0; i < NB; i++) begin
         if (i <= int'(extra)) rd_next[i*DW +: DW] = mem[addr + (AW+1)'(i)];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data  <= '0;
         error <= 1'b0;
      end else begin
         data  <= rd_ok ? rd_next : '0;
         error <= !rd_ok;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (wr_valid && wr_ok) state_next = WRITE;
         WRITE:   if (cnt == w_extra) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      wr_ready = (state == IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt      <= '0;
         w_addr   <= '0;
         w_extra  <= '0;
         w_data   <= '0;
         wr_done  <= 1'b0;
         wr_error <= 1'b0;
      end else begin
         wr_done  <= 1'b0;
         wr_error <= 1'b0;
         case (state)
            IDLE: begin
               if (wr_valid) begin
                  w_addr   <= wr_addr;
                  w_extra  <= wr_extra;
                  w_data   <= wr_data;
                  cnt      <= '0;
                  wr_error <= !wr_ok;
               end
            end
            WRITE: begin
               cnt <= cnt + 1'b1;
               if (cnt == w_extra) wr_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Memory has no reset; an asserted reset forces IDLE, which stops further stores.
   always_ff @(posedge clk) begin
      if (state == WRITE) mem[w_addr + (AW+1)'(cnt)] <= w_data[int'(cnt)*DW +: DW];
   end

endmodule

// File: tb/tb_genram.sv
// Self-checking bench for genram: constant vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_genram;

   localparam int AW = 5, DW = 8, EXTRA = 4, NB = 16, BW = 128, DEPTH = 64;

   logic            clk = 1'b0;
   logic            reset;
   logic [AW:0]     addr, lower_bound, upper_bound, wr_addr;
   logic [EXTRA-1:0] extra, wr_extra;
   logic [BW-1:0]   data, wr_data;
   logic            error, wr_valid, wr_ready, wr_done, wr_error;

   always #5 clk = ~clk;

   genram #(.AW(AW), .DW(DW), .EXTRA(EXTRA), .INITFILE("")) dut (
      .clk(clk), .reset(reset), .addr(addr), .extra(extra),
      .lower_bound(lower_bound), .upper_bound(upper_bound),
      .data(data), .error(error), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_addr(wr_addr), .wr_extra(wr_extra), .wr_data(wr_data),
      .wr_done(wr_done), .wr_error(wr_error)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: byte array plus a queue of byte stores still to happen, one per cycle.
   logic [7:0] mem_m [DEPTH];
   typedef struct { logic [5:0] a; logic [7:0] v; } wbyte_t;
   wbyte_t pend[$];

   typedef struct {
      logic [5:0]   a;
      logic [3:0]   e;
      logic [5:0]   lo;
      logic [5:0]   hi;
      logic         err;
      logic [127:0] d;
   } vec_t;
   vec_t tbl[10];

   task automatic check_output(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp_v);
      end
   endtask

   function automatic bit legal(input int a, input int e, input int lo, input int hi);
      return (a >= lo) && (a + e <= hi);
   endfunction

   function automatic logic [BW-1:0] read_model(input int a, input int e);
      logic [BW-1:0] r;
      r = '0;
      for (int i = 0; i <= e; i++) r[i*8 +: 8] = mem_m[(a + i) % DEPTH];
      return r;
   endfunction

   // One clock cycle: predict, advance past the edge, compare.
   task automatic apply_stimulus(input bit chk);
      logic [BW-1:0] exp_d;
      logic exp_e, exp_done, exp_werr;
      wbyte_t b;
      if (legal(int'(addr), int'(extra), int'(lower_bound), int'(upper_bound))) begin
         exp_d = read_model(int'(addr), int'(extra));
         exp_e = 1'b0;
      end else begin
         exp_d = '0;
         exp_e = 1'b1;
      end
      exp_done = 1'b0;
      exp_werr = 1'b0;
      if (chk) check_output("wr_ready", wr_ready, pend.size() == 0);
      if (pend.size() > 0) begin
         b = pend.pop_front();
         mem_m[b.a] = b.v;
         if (pend.size() == 0) exp_done = 1'b1;
      end else if (wr_valid) begin
         if (legal(int'(wr_addr), int'(wr_extra), int'(lower_bound), int'(upper_bound))) begin
            for (int i = 0; i <= int'(wr_extra); i++) begin
               b.a = 6'((int'(wr_addr) + i) % DEPTH);
               b.v = wr_data[i*8 +: 8];
               pend.push_back(b);
            end
         end else begin
            exp_werr = 1'b1;
         end
      end
      @(posedge clk); #1;
      if (chk) begin
         check_output("data", data, exp_d);
         check_output("error", error, exp_e);
         check_output("wr_done", wr_done, exp_done);
         check_output("wr_error", wr_error, exp_werr);
      end
   endtask

   initial begin
      int busy, dones, lo;
      bit found;

      reset = 1'b1; addr = '0; extra = '0; lower_bound = '0; upper_bound = 6'd63;
      wr_valid = 1'b0; wr_addr = '0; wr_extra = '0; wr_data = '0;
      repeat (2) @(posedge clk);
      #1;
      check_output("rst_data", data, '0);
      check_output("rst_error", error, 1'b0);
      check_output("rst_wr_done", wr_done, 1'b0);
      check_output("rst_wr_error", wr_error, 1'b0);
      check_output("rst_wr_ready", wr_ready, 1'b1);
      reset = 1'b0;

      // Fill memory with mem[i] = i so later expectations are known constants.
      for (int c = 0; c < 4; c++) begin
         wr_valid = 1'b1; wr_addr = 6'(c*16); wr_extra = 4'd15;
         for (int j = 0; j < 16; j++) wr_data[j*8 +: 8] = 8'(c*16 + j);
         apply_stimulus(0);
         wr_valid = 1'b0;
         repeat (16) apply_stimulus(0);
      end

      tbl[0] = '{6'd4,  4'd3,  6'd0,  6'd63, 1'b0, 128'h07060504};
      tbl[1] = '{6'd0,  4'd0,  6'd0,  6'd63, 1'b0, 128'h0};
      tbl[2] = '{6'd62, 4'd3,  6'd0,  6'd63, 1'b1, 128'h0};
      tbl[3] = '{6'd60, 4'd3,  6'd0,  6'd63, 1'b0, 128'h3f3e3d3c};
      tbl[4] = '{6'd10, 4'd1,  6'd16, 6'd63, 1'b1, 128'h0};
      tbl[5] = '{6'd16, 4'd0,  6'd16, 6'd16, 1'b0, 128'h10};
      tbl[6] = '{6'd16, 4'd1,  6'd16, 6'd16, 1'b1, 128'h0};
      tbl[7] = '{6'd48, 4'd15, 6'd0,  6'd63, 1'b0, 128'h3f3e3d3c3b3a39383736353433323130};
      tbl[8] = '{6'd63, 4'd0,  6'd0,  6'd63, 1'b0, 128'h3f};
      tbl[9] = '{6'd50, 4'd15, 6'd0,  6'd63, 1'b1, 128'h0};
      for (int k = 0; k < 10; k++) begin
         addr = tbl[k].a; extra = tbl[k].e; lower_bound = tbl[k].lo; upper_bound = tbl[k].hi;
         apply_stimulus(1);
         check_output("tbl_data", data, tbl[k].d);
         check_output("tbl_error", error, tbl[k].err);
      end
      lower_bound = 6'd0; upper_bound = 6'd63;

      // Four-byte write; wr_* changes while busy must be ignored.
      wr_valid = 1'b1; wr_addr = 6'd4; wr_extra = 4'd3; wr_data = 128'h04030201;
      apply_stimulus(1);
      wr_valid = 1'b0; wr_addr = 6'd0; wr_data = '1;
      busy = 0; dones = 0;
      for (int k = 0; k < 8; k++) begin
         if (!wr_ready) busy++;
         apply_stimulus(1);
         if (wr_done) dones++;
      end
      check_output("write4_busy_cycles", 128'(busy), 128'd4);
      check_output("write4_done_pulses", 128'(dones), 128'd1);
      addr = 6'd4; extra = 4'd3;
      apply_stimulus(1);
      check_output("write4_readback", data, 128'h04030201);

      // Out-of-bounds write is refused.
      lower_bound = 6'd16;
      wr_valid = 1'b1; wr_addr = 6'd10; wr_extra = 4'd0; wr_data = 128'h5a;
      apply_stimulus(1);
      wr_valid = 1'b0;
      check_output("oob_wr_error", wr_error, 1'b1);
      check_output("oob_wr_ready", wr_ready, 1'b1);
      lower_bound = 6'd0; addr = 6'd10; extra = 4'd0;
      apply_stimulus(1);
      check_output("oob_mem_unchanged", data, 128'h0a);

      // Read-before-write on the same byte.
      addr = 6'd20; extra = 4'd0;
      wr_valid = 1'b1; wr_addr = 6'd20; wr_extra = 4'd0; wr_data = 128'haa;
      apply_stimulus(1);
      wr_valid = 1'b0;
      apply_stimulus(1);
      check_output("rbw_old_value", data, 128'h14);
      apply_stimulus(1);
      check_output("rbw_new_value", data, 128'haa);

      // Back-to-back writes with wr_valid held high.
      wr_valid = 1'b1; wr_addr = 6'd30; wr_extra = 4'd1; wr_data = 128'hbbcc;
      apply_stimulus(1);
      wr_addr = 6'd40; wr_extra = 4'd0; wr_data = 128'hdd;
      found = 1'b0;
      for (int k = 0; k < 8 && !found; k++) begin
         apply_stimulus(1);
         if (wr_done) found = 1'b1;
      end
      check_output("b2b_done_seen", found, 1'b1);
      check_output("b2b_ready_with_done", wr_ready, 1'b1);
      apply_stimulus(1);
      check_output("b2b_second_accepted", wr_ready, 1'b0);
      wr_valid = 1'b0;
      repeat (3) apply_stimulus(1);

      // Reset after two bytes of an eight-byte write.
      wr_valid = 1'b1; wr_addr = 6'd0; wr_extra = 4'd7; wr_data = 128'hf7f6f5f4f3f2f1f0;
      apply_stimulus(1);
      wr_valid = 1'b0;
      repeat (2) apply_stimulus(1);
      reset = 1'b1;
      pend.delete();
      #1;
      check_output("midrst_wr_ready", wr_ready, 1'b1);
      check_output("midrst_data", data, '0);
      check_output("midrst_error", error, 1'b0);
      @(posedge clk); #1;
      check_output("midrst_wr_done", wr_done, 1'b0);
      check_output("midrst_wr_ready_held", wr_ready, 1'b1);
      reset = 1'b0;
      addr = 6'd0; extra = 4'd7;
      apply_stimulus(1);
      check_output("midrst_partial_mem", data, 128'h040302010302f1f0);

      // Randomized traffic.
      for (int k = 0; k < 400; k++) begin
         addr = 6'($urandom_range(0, 63));
         extra = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) begin
            lo = $urandom_range(0, 40);
            lower_bound = 6'(lo);
            upper_bound = 6'($urandom_range(lo, 63));
         end else begin
            lower_bound = 6'd0; upper_bound = 6'd63;
         end
         wr_valid = ($urandom_range(0, 2) == 0);
         wr_addr = 6'($urandom_range(0, 63));
         wr_extra = 4'($urandom_range(0, 7));
         wr_data = {$urandom, $urandom, $urandom, $urandom};
         apply_stimulus(1);
      end
      wr_valid = 1'b0; lower_bound = 6'd0; upper_bound = 6'd63;
      repeat (20) apply_stimulus(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
